// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hazard and data-memory wait controller.
// Resolves memory-wait holds, taken-branch flushes and load-use stalls
// in priority order, with a timeout that aborts a stuck memory access.
// Optional feature macro: PIPE_CTRL_STATS_EN adds stallCycles/flushCount.
module pipe_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 8     // MEM_TIMEOUT must fit below 2**CNT_W
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  idRs,
    input  logic [4:0]  idRt,
    input  logic        exMemRead,
    input  logic [4:0]  exWriteReg,
    input  logic        exBranchTaken,
    input  logic        memMemRead,
    input  logic        memMemWrite,
    input  logic        dmemReady,
    output logic        dmemReq,
    output logic        ifStall,
    output logic        idStall,
    output logic        exBubble,
    output logic        ifFlush,
    output logic        idFlush,
    output logic        memHold,
    output logic        memError,
`ifdef PIPE_CTRL_STATS_EN
    output logic [31:0] stallCycles,
    output logic [31:0] flushCount,
`endif
    output logic [1:0]  state
);

    localparam logic [1:0] S_RUN     = 2'd0;
    localparam logic [1:0] S_MEMWAIT = 2'd1;
    localparam logic [1:0] S_ABORT   = 2'd2;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

    logic [1:0]       state_reg, state_next;
    logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;

    logic access;
    logic load_use;
    logic hold;

    assign access   = memMemRead | memMemWrite;
    // $0 is hardwired to zero, so a load targeting it never creates a hazard.
    assign load_use = exMemRead && (exWriteReg != 5'd0) &&
                      ((exWriteReg == idRs) || (exWriteReg == idRt));
    assign state    = state_reg;

    // Next-state, wait counter and all control outputs; reset forces outputs low.
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        hold          = 1'b0;
        dmemReq       = 1'b0;
        ifStall       = 1'b0;
        idStall       = 1'b0;
        exBubble      = 1'b0;
        ifFlush       = 1'b0;
        idFlush       = 1'b0;
        memHold       = 1'b0;
        memError      = 1'b0;
        if (!reset) begin
            case (state_reg)
                S_RUN: begin
                    dmemReq = access;
                    if (access && !dmemReady) begin
                        hold          = 1'b1;
                        state_next    = S_MEMWAIT;
                        wait_cnt_next = ONE_C;
                    end
                end
                S_MEMWAIT: begin
                    dmemReq = access;
                    if (dmemReady) begin
                        state_next    = S_RUN;
                        wait_cnt_next = '0;
                    end else begin
                        hold = 1'b1;
                        if (wait_cnt_reg == TIMEOUT_C) begin
                            state_next    = S_ABORT;
                            wait_cnt_next = '0;
                        end else if (wait_cnt_reg < TIMEOUT_C) begin
                            wait_cnt_next = wait_cnt_reg + ONE_C;
                        end
                    end
                end
                S_ABORT: begin
                    // Drop the faulted access and squash everything younger.
                    memError      = 1'b1;
                    ifFlush       = 1'b1;
                    idFlush       = 1'b1;
                    exBubble      = 1'b1;
                    state_next    = S_RUN;
                    wait_cnt_next = '0;
                end
                default: begin
                    state_next    = S_RUN;
                    wait_cnt_next = '0;
                end
            endcase

            // Hold wins; a held branch or load-use stays in place and is
            // acted on in the first unheld cycle.
            if (state_reg != S_ABORT) begin
                if (hold) begin
                    memHold = 1'b1;
                    ifStall = 1'b1;
                    idStall = 1'b1;
                end else if (exBranchTaken) begin
                    ifFlush = 1'b1;
                    idFlush = 1'b1;
                end else if (load_use) begin
                    ifStall  = 1'b1;
                    idStall  = 1'b1;
                    exBubble = 1'b1;
                end
            end
        end
    end

    // Controller state and wait counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= S_RUN;
            wait_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

`ifdef PIPE_CTRL_STATS_EN
    logic [31:0] stall_cycles_reg;
    logic [31:0] flush_count_reg;

    assign stallCycles = stall_cycles_reg;
    assign flushCount  = flush_count_reg;

    // Free-running statistics; both wrap naturally at 2**32.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_reg <= '0;
            flush_count_reg  <= '0;
        end else begin
            if (ifStall || memHold) stall_cycles_reg <= stall_cycles_reg + 32'd1;
            if (ifFlush)            flush_count_reg  <= flush_count_reg + 32'd1;
        end
    end
`endif

endmodule
